reqfifo_drain: RTL and testbench
================================

Name: reqfifo_drain

Overview:
- Single-clock read-side consumer of the 640-bit request FIFO in mc_top, running in the FIFO's read-clock domain.
- Issues FIFO reads under credit control and absorbs the FIFO read latency in a small output buffer.
- Decodes each 640-bit word into request fields, drops malformed entries, and presents requests to the memory-controller command path over a valid/ready handshake, in FIFO order.

Parameters:
- FIFO_RD_LAT, 1, cycles from fifo_rdreq to valid fifo_q (normal, non-show-ahead FIFO); legal values 1..2.
- OBUF_DEPTH, 4, output buffer entries; must be >= FIFO_RD_LAT+2 for full throughput.
- CNT_W, 32, width of the statistics counters.

Ports:
- clk  in  1  read-side clock; same clock as the FIFO rdclk.
- reset  in  1  synchronous, active-high.
- fifo_q  in  640  FIFO read data.
- fifo_rdempty  in  1  FIFO empty flag, read-clock domain.
- fifo_rdreq  out  1  FIFO read request.
- mc_req_valid  out  1  request available.
- mc_req_ready  in  1  consumer accepts the request.
- mc_req_is_wr  out  1  1 = write, 0 = read.
- mc_req_addr  out  46  cacheline address.
- mc_req_tag  out  12  request tag.
- mc_req_wdata  out  512  write data; don't-care for reads.
- mc_req_byteen  out  64  byte enables; don't-care for reads.
- drop_pulse  out  1  one-cycle pulse per dropped entry.
- drop_cnt  out  CNT_W  saturating count of dropped entries.
- issue_cnt  out  CNT_W  wrapping count of accepted requests.
- busy  out  1  buffer occupied or FIFO read in flight.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (reset).
- Word layout: [511:0] wdata, [575:512] byteen, [621:576] addr, [623:622] cmd, [635:624] tag, [639:636] reserved.
- cmd encoding: 2'b00 = read, 2'b01 = write, 2'b1x = illegal.
- Reset values: fifo_rdreq=0, mc_req_valid=0, drop_pulse=0, drop_cnt=0, issue_cnt=0, busy=0; buffer and in-flight pipeline cleared.
- Credit rule: fifo_rdreq = !fifo_rdempty && (occ + inflight) < OBUF_DEPTH.
  - occ and inflight are registered values at cycle start.
  - No combinational path from mc_req_ready to fifo_rdreq.
- In-flight tracking: a FIFO_RD_LAT-deep valid shift register tracks reads; fifo_q is sampled on the cycle its tag bit exits.
- Decode on capture:
  - Legal word (cmd[1]==0, reserved==0): written to buffer tail.
  - Illegal word: discarded, drop_pulse=1 for that cycle, drop_cnt += 1, saturating at all-ones.
  - Discarded words release their credit immediately because they never occupy the buffer.
- Output: mc_req_* driven from the buffer head; mc_req_valid = (occ != 0).
  - While valid && !ready, all mc_req_* hold stable.
  - valid && ready: head pops, issue_cnt += 1 with wrap.
- Simultaneous capture and pop: occ unchanged; capture into a full buffer cannot occur by credit construction.
- Ordering: strictly FIFO order; zero added latency when the buffer is non-empty and ready is high.
- Min latency: FIFO word to mc_req_valid is FIFO_RD_LAT+1 cycles after fifo_rdreq (capture registered).
- Throughput: 1 request/cycle sustained with the default parameters.
- Pointer wrap: buffer pointers are log2(OBUF_DEPTH) bits and wrap naturally; occ is a separate counter of width log2(OBUF_DEPTH)+1.
- Reset mid-operation:
  - In-flight reads are abandoned and buffer contents are lost.
  - The parent drives the FIFO aclr from the same reset, so no stale word is returned after reset deasserts.
- busy = (occ != 0) || (inflight != 0).
- Assertions:
  - fifo_rdreq never high while fifo_rdempty.
  - occ never exceeds OBUF_DEPTH.
  - mc_req_* stable while stalled.

Decomposition:
- Package mc_req_pkg:
  - Field offsets/widths: WDATA_LSB, BYTEEN_LSB, ADDR_LSB, CMD_LSB, TAG_LSB, RSVD_LSB.
  - REQ_W=640.
  - cmd enum: CMD_RD, CMD_WR.
  - Unpacked request struct type.
- Sub-module reqfifo_obuf: parameterised synchronous circular buffer with push/pop, occ output and head data.
  - The drain instantiates it once; credit logic, decode and counters stay in the top.

Test Plan:
- Back-to-back: preload FIFO with 16 legal reads (tags 0..15), ready tied 1 -> 16 consecutive valid cycles, tags in order 0..15, issue_cnt=16, fifo_rdreq never high while rdempty.
- Backpressure: 8 writes, ready low for 10 cycles then high -> at most OBUF_DEPTH+0 reads issued while stalled (occ caps at 4); head fields stable; all 8 delivered in order afterwards.
- Illegal drop: sequence read(tag 1), cmd=2'b10(tag 2), reserved=4'h1(tag 3), write(tag 4) -> outputs tags 1,4 only; two drop_pulse cycles; drop_cnt=2.
- Latency: single read into idle FIFO, FIFO_RD_LAT=1 -> mc_req_valid rises exactly 2 cycles after fifo_rdreq; repeat with FIFO_RD_LAT=2 -> 3 cycles.
- Reset mid-stream: assert reset with occ=3 and one read in flight -> next cycle mc_req_valid=0, busy=0, counters 0; after release, new words drain normally with no stale output.
- Counter saturation: force drop_cnt to all-ones, inject an illegal word -> drop_cnt stays all-ones and drop_pulse still fires.

Source files
------------

// File: rtl/mc_req_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mc_req_pkg
// Purpose  : Field map and decode helpers for 640-bit request FIFO words.
// Revision : 1.0
// ============================================================================
package mc_req_pkg;

    localparam int REQ_W      = 640;
    localparam int WDATA_LSB  = 0;
    localparam int WDATA_W    = 512;
    localparam int BYTEEN_LSB = 512;
    localparam int BYTEEN_W   = 64;
    localparam int ADDR_LSB   = 576;
    localparam int ADDR_W     = 46;
    localparam int CMD_LSB    = 622;
    localparam int CMD_W      = 2;
    localparam int TAG_LSB    = 624;
    localparam int TAG_W      = 12;
    localparam int RSVD_LSB   = 636;
    localparam int RSVD_W     = 4;

    typedef enum logic [CMD_W-1:0] {
        CMD_RD = 2'b00,
        CMD_WR = 2'b01
    } cmd_e;

    typedef struct packed {
        logic                is_wr;
        logic [ADDR_W-1:0]   addr;
        logic [TAG_W-1:0]    tag;
        logic [BYTEEN_W-1:0] byteen;
        logic [WDATA_W-1:0]  wdata;
    } req_t;

    function automatic logic word_legal(input logic [REQ_W-1:0] w);
        return !w[CMD_LSB+1] && (w[RSVD_LSB +: RSVD_W] == '0);
    endfunction

    function automatic req_t word_decode(input logic [REQ_W-1:0] w);
        req_t r;
        r.is_wr  = (w[CMD_LSB +: CMD_W] == CMD_WR);
        r.addr   = w[ADDR_LSB +: ADDR_W];
        r.tag    = w[TAG_LSB +: TAG_W];
        r.byteen = w[BYTEEN_LSB +: BYTEEN_W];
        r.wdata  = w[WDATA_LSB +: WDATA_W];
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/reqfifo_obuf.sv
`default_nettype none
// ============================================================================
// Module   : reqfifo_obuf
// Purpose  : Synchronous circular buffer with occupancy count and head data.
// Revision : 1.0
// ============================================================================
module reqfifo_obuf #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_push,
    input  logic [W-1:0]          i_din,
    input  logic                  i_pop,
    output logic [$clog2(DEPTH):0] o_occ,
    output logic [W-1:0]          o_head
);

    localparam int c_ptr_w = $clog2(DEPTH);

    logic [W-1:0]       r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_ptr_w:0]   r_occ;

    function automatic logic [c_ptr_w-1:0] ptr_next(input logic [c_ptr_w-1:0] p);
        return (p == c_ptr_w'(DEPTH-1)) ? '0 : p + 1'b1;
    endfunction

    // Storage is not reset: only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= ptr_next(r_wr_ptr);
            end
            if (i_pop) begin
                r_rd_ptr <= ptr_next(r_rd_ptr);
            end
            case ({i_push, i_pop})
                2'b10:   r_occ <= r_occ + 1'b1;
                2'b01:   r_occ <= r_occ - 1'b1;
                default: r_occ <= r_occ;
            endcase
        end
    end

    assign o_occ  = r_occ;
    assign o_head = r_mem[r_rd_ptr];

    a_occ_bound: assert property (@(posedge clk) disable iff (reset)
        r_occ <= (c_ptr_w+1)'(DEPTH));

endmodule
`default_nettype wire

// File: rtl/reqfifo_drain.sv
`default_nettype none
// ============================================================================
// Module   : reqfifo_drain
// Purpose  : Credit-controlled reader of the request FIFO; decodes, drops
//            malformed words and presents requests over valid/ready.
// Revision : 1.0
// ============================================================================
module reqfifo_drain
    import mc_req_pkg::*;
#(
    parameter int FIFO_RD_LAT = 1,
    parameter int OBUF_DEPTH  = 4,
    parameter int CNT_W       = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [REQ_W-1:0]   fifo_q,
    input  logic               fifo_rdempty,
    output logic               fifo_rdreq,
    output logic               mc_req_valid,
    input  logic               mc_req_ready,
    output logic               mc_req_is_wr,
    output logic [ADDR_W-1:0]  mc_req_addr,
    output logic [TAG_W-1:0]   mc_req_tag,
    output logic [WDATA_W-1:0] mc_req_wdata,
    output logic [BYTEEN_W-1:0] mc_req_byteen,
    output logic               drop_pulse,
    output logic [CNT_W-1:0]   drop_cnt,
    output logic [CNT_W-1:0]   issue_cnt,
    output logic               busy
);

    localparam int c_occ_w = $clog2(OBUF_DEPTH) + 1;

    logic [FIFO_RD_LAT-1:0] r_vld_sr;
    logic [c_occ_w-1:0]     r_infl;
    logic [c_occ_w-1:0]     w_occ;
    logic [c_occ_w:0]       w_credit_sum;
    logic                   w_rdreq;
    logic                   w_exit;
    logic                   w_push;
    logic                   w_drop;
    logic                   w_pop;
    req_t                   w_dec;
    req_t                   w_head;
    logic                   r_drop_pulse;
    logic [CNT_W-1:0]       r_drop_cnt;
    logic [CNT_W-1:0]       r_issue_cnt;

    // Credits come only from registered occupancy/in-flight state, so ready
    // never reaches the FIFO read request combinationally.
    assign w_credit_sum = {1'b0, w_occ} + {1'b0, r_infl};
    assign w_rdreq      = !reset && !fifo_rdempty &&
                          (w_credit_sum < (c_occ_w+1)'(OBUF_DEPTH));

    assign w_exit = r_vld_sr[FIFO_RD_LAT-1];
    assign w_dec  = word_decode(fifo_q);
    assign w_push = w_exit && word_legal(fifo_q);
    assign w_drop = w_exit && !word_legal(fifo_q);
    assign w_pop  = mc_req_valid && mc_req_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_vld_sr     <= '0;
            r_infl       <= '0;
            r_drop_pulse <= 1'b0;
            r_drop_cnt   <= '0;
            r_issue_cnt  <= '0;
        end else begin
            r_vld_sr     <= (r_vld_sr << 1) | FIFO_RD_LAT'(w_rdreq);
            r_infl       <= r_infl + c_occ_w'(w_rdreq) - c_occ_w'(w_exit);
            r_drop_pulse <= w_drop;
            if (w_drop && (r_drop_cnt != '1)) begin
                r_drop_cnt <= r_drop_cnt + CNT_W'(1);
            end
            if (w_pop) begin
                r_issue_cnt <= r_issue_cnt + CNT_W'(1);
            end
        end
    end

    reqfifo_obuf #(
        .DEPTH (OBUF_DEPTH),
        .W     ($bits(req_t))
    ) u_obuf (
        .clk    (clk),
        .reset  (reset),
        .i_push (w_push),
        .i_din  (w_dec),
        .i_pop  (w_pop),
        .o_occ  (w_occ),
        .o_head (w_head)
    );

    assign fifo_rdreq    = w_rdreq;
    assign mc_req_valid  = (w_occ != '0);
    assign mc_req_is_wr  = w_head.is_wr;
    assign mc_req_addr   = w_head.addr;
    assign mc_req_tag    = w_head.tag;
    assign mc_req_wdata  = w_head.wdata;
    assign mc_req_byteen = w_head.byteen;
    assign drop_pulse    = r_drop_pulse;
    assign drop_cnt      = r_drop_cnt;
    assign issue_cnt     = r_issue_cnt;
    assign busy          = (w_occ != '0) || (r_infl != '0);

    a_no_rd_empty: assert property (@(posedge clk) disable iff (reset)
        !(fifo_rdreq && fifo_rdempty));

    a_stall_hold: assert property (@(posedge clk) disable iff (reset)
        (mc_req_valid && !mc_req_ready) |=> (mc_req_valid && $stable(w_head)));

endmodule
`default_nettype wire

// File: tb/tb_reqfifo_drain.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_reqfifo_drain
// Purpose  : Directed bench for reqfifo_drain with FIFO models at read
//            latencies 1 (unit A) and 2 (unit B, 2-bit counters).
// Revision : 1.0
// ============================================================================
module tb_reqfifo_drain;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    // ---------------- unit A: FIFO_RD_LAT=1 ----------------
    logic [639:0] qa = '0;
    logic         ea, rra, va, rdya, wra, dpa, busya;
    logic [45:0]  addra;
    logic [11:0]  taga;
    logic [511:0] wda;
    logic [63:0]  bea;
    logic [31:0]  dca, ica;
    logic [639:0] mema [64];
    logic [5:0]   wpa = '0;
    logic [5:0]   rpa = '0;
    assign ea = (wpa == rpa);
    always @(posedge clk) if (rra) begin qa <= mema[rpa]; rpa <= rpa + 6'd1; end

    reqfifo_drain #(.FIFO_RD_LAT(1), .OBUF_DEPTH(4), .CNT_W(32)) u_dut_a (
        .clk(clk), .reset(reset), .fifo_q(qa), .fifo_rdempty(ea), .fifo_rdreq(rra),
        .mc_req_valid(va), .mc_req_ready(rdya), .mc_req_is_wr(wra), .mc_req_addr(addra),
        .mc_req_tag(taga), .mc_req_wdata(wda), .mc_req_byteen(bea), .drop_pulse(dpa),
        .drop_cnt(dca), .issue_cnt(ica), .busy(busya));

    // ---------------- unit B: FIFO_RD_LAT=2, CNT_W=2 ----------------
    logic [639:0] qb = '0;
    logic [639:0] s1b = '0;
    logic         eb, rrb, vb, rdyb, wrb, dpb, busyb;
    logic [45:0]  addrb;
    logic [11:0]  tagb;
    logic [511:0] wdb;
    logic [63:0]  beb;
    logic [1:0]   dcb, icb;
    logic [639:0] memb [64];
    logic [5:0]   wpb = '0;
    logic [5:0]   rpb = '0;
    assign eb = (wpb == rpb);
    always @(posedge clk) begin
        s1b <= memb[rpb];
        qb  <= s1b;
        if (rrb) rpb <= rpb + 6'd1;
    end

    reqfifo_drain #(.FIFO_RD_LAT(2), .OBUF_DEPTH(4), .CNT_W(2)) u_dut_b (
        .clk(clk), .reset(reset), .fifo_q(qb), .fifo_rdempty(eb), .fifo_rdreq(rrb),
        .mc_req_valid(vb), .mc_req_ready(rdyb), .mc_req_is_wr(wrb), .mc_req_addr(addrb),
        .mc_req_tag(tagb), .mc_req_wdata(wdb), .mc_req_byteen(beb), .drop_pulse(dpb),
        .drop_cnt(dcb), .issue_cnt(icb), .busy(busyb));

    // ---------------- word builders ----------------
    function automatic logic [511:0] wd_of(input logic [11:0] tag);
        return {16{tag ^ 12'hA5A, 20'hC0FFE}};
    endfunction
    function automatic logic [63:0] be_of(input logic [11:0] tag);
        return {4{~tag[3:0], tag}};
    endfunction
    function automatic logic [639:0] mk(input logic [1:0] cmd, input logic [3:0] rsvd,
                                        input logic [11:0] tag, input logic [45:0] addr);
        return {rsvd, tag, cmd, addr, be_of(tag), wd_of(tag)};
    endfunction

    // ---------------- monitors (sampled mid-cycle) ----------------
    logic [11:0]  cap_tag [64];
    logic         cap_wr  [64];
    logic [45:0]  cap_addr[64];
    logic [511:0] cap_wd  [64];
    logic [63:0]  cap_be  [64];
    int           cap_cyc [64];
    int ncap_a = 0, rrcnt_a = 0, drops_a = 0, rdemp_a = 0, stab_a = 0, rise_a = 0, lastrr_a = 0;
    logic         pstall = 1'b0, pva = 1'b0, pwr = 1'b0;
    logic [45:0]  paddr = '0;
    logic [11:0]  ptag = '0;
    logic [511:0] pwd = '0;
    logic [63:0]  pbe = '0;

    always @(negedge clk) begin
        #1;
        if (!reset) begin
            if (rra) begin rrcnt_a++; lastrr_a = cyc; end
            if (rra && ea) rdemp_a++;
            if (dpa) drops_a++;
            if (va && !pva) rise_a = cyc;
            if (pstall && (!va || ({taga, addra, wra, wda, bea} != {ptag, paddr, pwr, pwd, pbe})))
                stab_a++;
            if (va && rdya && ncap_a < 64) begin
                cap_tag[ncap_a] = taga;  cap_wr[ncap_a] = wra;  cap_addr[ncap_a] = addra;
                cap_wd[ncap_a]  = wda;   cap_be[ncap_a] = bea;  cap_cyc[ncap_a]  = cyc;
                ncap_a++;
            end
        end
        pstall = !reset && va && !rdya;
        pva    = !reset && va;
        ptag = taga; paddr = addra; pwr = wra; pwd = wda; pbe = bea;
    end

    int ncap_b = 0, drops_b = 0, rdemp_b = 0, rise_b = 0, lastrr_b = 0;
    logic         pvb = 1'b0, lwrb = 1'b0;
    logic [11:0]  ltagb = '0;
    logic [45:0]  laddrb = '0;
    logic [511:0] lwdb = '0;
    logic [63:0]  lbeb = '0;

    always @(negedge clk) begin
        #1;
        if (!reset) begin
            if (rrb) lastrr_b = cyc;
            if (rrb && eb) rdemp_b++;
            if (dpb) drops_b++;
            if (vb && !pvb) rise_b = cyc;
            if (vb && rdyb) begin
                ltagb = tagb; laddrb = addrb; lwrb = wrb; lwdb = wdb; lbeb = beb;
                ncap_b++;
            end
        end
        pvb = !reset && vb;
    end

    // ---------------- helpers ----------------
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin @(posedge clk); #2; end
    endtask

    task automatic push_a(input logic [639:0] w);
        mema[wpa] = w; wpa = wpa + 6'd1;
    endtask

    task automatic push_b(input logic [639:0] w);
        memb[wpb] = w; wpb = wpb + 6'd1;
    endtask

    task automatic wait_a(input int n);
        int k = 0;
        while (ncap_a < n && k < 200) begin step(1); k++; end
        if (ncap_a < n) chk("wait_a timeout", 64'(ncap_a), 64'(n));
    endtask

    typedef struct {
        logic [1:0]  cmd;
        logic [3:0]  rsvd;
        logic [11:0] tag;
        logic [45:0] addr;
        logic        exp_ok;
        logic        exp_wr;
    } vec_t;

    vec_t tv [6];
    int base, d0, r0, j;

    initial begin
        tv[0] = '{2'b00, 4'h0, 12'h001, 46'h0000_0000_1000, 1'b1, 1'b0};
        tv[1] = '{2'b10, 4'h0, 12'h002, 46'h0000_0000_2000, 1'b0, 1'b0};
        tv[2] = '{2'b00, 4'h1, 12'h003, 46'h0000_0000_3000, 1'b0, 1'b0};
        tv[3] = '{2'b01, 4'h0, 12'h004, 46'h3FFF_FFFF_FFFF, 1'b1, 1'b1};
        tv[4] = '{2'b11, 4'h0, 12'h005, 46'h0000_0000_5000, 1'b0, 1'b0};
        tv[5] = '{2'b01, 4'h0, 12'hFFF, 46'h0000_0000_0000, 1'b1, 1'b1};

        reset = 1'b1; rdya = 1'b1; rdyb = 1'b1;
        step(3);
        chk("rst A valid", 64'(va), 0);     chk("rst A rdreq", 64'(rra), 0);
        chk("rst A busy", 64'(busya), 0);   chk("rst A drop_cnt", 64'(dca), 0);
        chk("rst A issue_cnt", 64'(ica), 0); chk("rst A drop_pulse", 64'(dpa), 0);
        chk("rst B valid", 64'(vb), 0);     chk("rst B busy", 64'(busyb), 0);
        chk("rst B drop_cnt", 64'(dcb), 0);
        reset = 1'b0;
        step(2);

        // back-to-back: 16 reads, ready high
        base = ncap_a;
        for (int i = 0; i < 16; i++) push_a(mk(2'b00, 4'h0, 12'(i), 46'(i * 64)));
        wait_a(base + 16);
        for (int i = 0; i < 16; i++) chk("b2b tag", 64'(cap_tag[base+i]), 64'(i));
        chk("b2b consecutive span", 64'(cap_cyc[base+15] - cap_cyc[base]), 15);
        step(3);
        chk("b2b issue_cnt", 64'(ica), 16);

        // table: legal/illegal mix, drops filtered, order kept
        base = ncap_a; d0 = drops_a;
        for (int i = 0; i < 6; i++) push_a(mk(tv[i].cmd, tv[i].rsvd, tv[i].tag, tv[i].addr));
        wait_a(base + 3);
        step(6);
        chk("tbl delivered", 64'(ncap_a - base), 3);
        j = base;
        for (int i = 0; i < 6; i++) begin
            if (tv[i].exp_ok) begin
                chk("tbl tag", 64'(cap_tag[j]), 64'(tv[i].tag));
                chk("tbl is_wr", 64'(cap_wr[j]), 64'(tv[i].exp_wr));
                chk("tbl addr", 64'(cap_addr[j]), 64'(tv[i].addr));
                chk("tbl wdata", 64'(cap_wd[j] == wd_of(tv[i].tag)), 1);
                chk("tbl byteen", cap_be[j], be_of(tv[i].tag));
                j++;
            end
        end
        chk("tbl drop pulses", 64'(drops_a - d0), 3);
        chk("tbl drop_cnt", 64'(dca), 3);
        chk("tbl issue_cnt", 64'(ica), 19);

        // backpressure: 8 writes with ready low for 10 cycles
        rdya = 1'b0; base = ncap_a; r0 = rrcnt_a;
        for (int i = 0; i < 8; i++) push_a(mk(2'b01, 4'h0, 12'h020 + 12'(i), 46'h100 + 46'(i)));
        step(10);
        chk("bp reads while stalled", 64'(rrcnt_a - r0), 4);
        chk("bp valid", 64'(va), 1);
        chk("bp head tag", 64'(taga), 64'h020);
        chk("bp busy", 64'(busya), 1);
        chk("bp none accepted", 64'(ncap_a - base), 0);
        rdya = 1'b1;
        wait_a(base + 8);
        for (int i = 0; i < 8; i++) begin
            chk("bp tag", 64'(cap_tag[base+i]), 64'h020 + 64'(i));
            chk("bp addr", 64'(cap_addr[base+i]), 64'h100 + 64'(i));
        end
        chk("bp stall stability", 64'(stab_a), 0);

        // latency, FIFO_RD_LAT=1
        step(4);
        push_a(mk(2'b00, 4'h0, 12'h055, 46'h55));
        step(8);
        chk("lat A rdreq->valid", 64'(rise_a - lastrr_a), 2);
        chk("lat A tag", 64'(cap_tag[ncap_a-1]), 64'h055);

        // latency, FIFO_RD_LAT=2
        push_b(mk(2'b01, 4'h0, 12'h066, 46'h1234));
        step(10);
        chk("lat B rdreq->valid", 64'(rise_b - lastrr_b), 3);
        chk("lat B tag", 64'(ltagb), 64'h066);
        chk("lat B is_wr", 64'(lwrb), 1);
        chk("lat B addr", 64'(laddrb), 64'h1234);
        chk("lat B wdata", 64'(lwdb == wd_of(12'h066)), 1);
        chk("lat B byteen", lbeb, be_of(12'h066));
        chk("lat B issue_cnt", 64'(icb), 1);
        chk("lat B drop_cnt", 64'(dcb), 0);

        // drop counter saturation on 2-bit counter
        d0 = drops_b; base = ncap_b;
        for (int i = 0; i < 3; i++) push_b(mk(2'b10, 4'h0, 12'h070 + 12'(i), 46'h0));
        step(12);
        chk("sat B drop_cnt at max", 64'(dcb), 3);
        chk("sat B pulses 3", 64'(drops_b - d0), 3);
        push_b(mk(2'b11, 4'h0, 12'h073, 46'h0));
        step(12);
        chk("sat B drop_cnt held", 64'(dcb), 3);
        chk("sat B pulses 4", 64'(drops_b - d0), 4);
        chk("sat B nothing delivered", 64'(ncap_b - base), 0);
        chk("sat B idle", 64'(busyb), 0);

        // reset with occ=3 and one read in flight
        rdya = 1'b0;
        for (int i = 0; i < 8; i++) push_a(mk(2'b00, 4'h0, 12'h040 + 12'(i), 46'h40));
        step(4);
        chk("pre-reset valid", 64'(va), 1);
        chk("pre-reset busy", 64'(busya), 1);
        reset = 1'b1;
        wpa = rpa;
        step(1);
        chk("mid-rst valid", 64'(va), 0);       chk("mid-rst busy", 64'(busya), 0);
        chk("mid-rst issue_cnt", 64'(ica), 0);  chk("mid-rst drop_cnt", 64'(dca), 0);
        chk("mid-rst rdreq", 64'(rra), 0);
        reset = 1'b0;
        rdya = 1'b1;
        step(2);
        base = ncap_a;
        push_a(mk(2'b00, 4'h0, 12'h050, 46'h50));
        push_a(mk(2'b01, 4'h0, 12'h051, 46'h51));
        wait_a(base + 2);
        step(8);
        chk("post-rst count", 64'(ncap_a - base), 2);
        chk("post-rst tag0", 64'(cap_tag[base]), 64'h050);
        chk("post-rst tag1", 64'(cap_tag[base+1]), 64'h051);
        chk("post-rst issue_cnt", 64'(ica), 2);

        chk("A rdreq while empty", 64'(rdemp_a), 0);
        chk("B rdreq while empty", 64'(rdemp_b), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
